divider_q: RTL
==============

Name: divider_q

Overview:
- Parametrised successor to the team's iterative `divider`.
- Adds:
  - signed/unsigned mode selected per operation;
  - fractional (Q-format) quotient bits;
  - remainder output;
  - a separate divide-by-zero flag;
  - valid/ready handshakes on input and output;
  - saturation on overflow.
- Sits in the Demodulator datapath and performs normalisation and ratio computations on I/Q magnitudes.
- One restoring iteration per clock.

Parameters:
- DATA_WIDTH, 32, width of dividend, divisor, quotient and remainder (W).
- FRAC_BITS, 0, number of fractional quotient bits (F); dividend is internally scaled by 2^F. Range 0..W.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; returns the block to IDLE.
- in_valid  in  1  operand request.
- in_ready  out  1  block can accept; high only in IDLE.
- in_signed  in  1  1 = two's-complement operands, 0 = unsigned.
- dividend  in  W  numerator.
- divisor  in  W  denominator.
- out_valid  out  1  result available; high only in DONE.
- out_ready  in  1  consumer accepts result.
- quotient  out  W  result in Q(W-F).F format, saturated on overflow.
- remainder  out  W  remainder of (dividend·2^F)/divisor; sign follows dividend (truncating).
- overflow  out  1  quotient saturated; includes divide-by-zero.
- div_by_zero  out  1  divisor was 0.

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE;
  - in_ready = 1, out_valid = 0;
  - quotient, remainder, overflow and div_by_zero = 0;
  - any in-flight operation is discarded with no output.
- Accept: on a rising edge with in_valid && in_ready, latch in_signed, dividend and divisor, then go to PREP. Inputs are ignored in all other states.
- PREP (1 cycle):
  - Form magnitudes |a| and |b|; sign is used only if in_signed.
  - Result sign = sa XOR sb; remainder sign = sa.
  - Load the N = W+F bit shift register with |a|<<F.
  - If divisor == 0, go to FIX with dz = 1; otherwise go to ITER with count = N-1.
- ITER (N cycles): restoring step.
  - Partial remainder (W+1 bits) = {rem, msb of shift register}.
  - If it is ≥ |b|: subtract, and shift 1 into the quotient magnitude; otherwise shift 0.
  - Decrement count; go to FIX after count reaches 0.
- FIX (1 cycle):
  - Overflow test on the N-bit magnitude m:
    - unsigned: overflow if m > 2^W-1;
    - signed positive result: overflow if m > 2^(W-1)-1;
    - signed negative result: overflow if m > 2^(W-1).
  - On overflow, quotient saturates: unsigned → all ones; signed positive → 0x7F..F; signed negative → 0x80..0.
  - Otherwise quotient = sign-applied m[W-1:0].
  - Remainder gets its sign applied.
  - Divide-by-zero:
    - quotient = saturated positive, or saturated negative if the dividend is signed negative (all ones if unsigned);
    - remainder = dividend;
    - overflow = 1, div_by_zero = 1.
  - Go to DONE.
- DONE:
  - out_valid = 1; all outputs held stable while out_ready = 0.
  - On out_ready, go to IDLE.
  - Outputs keep their last value until the next FIX; out_valid drops.
- Latency:
  - normal: out_valid rises N+2 edges after the accepting edge (W=32, F=0 → 34);
  - divide-by-zero: 2 edges.
  - Throughput: one operation per N+4 cycles minimum (accept, N+2 internal, DONE→IDLE).
- The ITER counter width is $clog2(N+1). No multi-bit subtract wider than W+1 bits.

Decomposition:
- Package `divider_q_pkg`:
  - `div_state_t` enum: IDLE, PREP, ITER, FIX, DONE;
  - function `sat_value(W, signed, neg)` returning the saturation constant.
- Single sub-module `div_restore_step`: combinational, one compare/subtract/shift step. This keeps the FSM readable and allows a future radix-4 or unrolled variant.

Test Plan (W=32, F=0 unless noted):
1. Signed 8 / 3 → after 34 edges: quotient 2, remainder 2, overflow 0, div_by_zero 0. in_ready low throughout.
2. Signed -1024 / 3 → quotient -341 (0xFFFFFEAB), remainder -1; unsigned 0xFFFFFFFF / 2 → quotient 0x7FFFFFFF, remainder 1.
3. Signed 0x80000000 / -1 → overflow 1, quotient 0x7FFFFFFF, div_by_zero 0.
4. 5 / 0 (signed) → out_valid 2 edges after accept: quotient 0x7FFFFFFF, remainder 5, overflow 1, div_by_zero 1. Also -5 / 0 → quotient 0x80000000.
5. F=16 instance, 1 / 3 → quotient 0x00005555, remainder 1, latency 50. Also 0x00010000 / 1 (i.e. 65536) → overflow 1, saturated quotient.
6. Handshake/reset:
   - Hold out_ready low for 5 cycles → outputs stable, in_ready 0; a second in_valid is ignored.
   - Assert reset mid-ITER → next cycle in_ready 1, out_valid 0, all outputs 0; no stale result appears later.

Source files
------------

// File: rtl/divider_q_pkg.sv
// Shared types and constants for the Q-format restoring divider.
// The saturation helper is evaluated at elaboration time by divider_q.
package divider_q_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } div_state_t;

  // Saturation constant for a w-bit quotient, right-aligned in MAX_W bits.
  function automatic logic [MAX_W-1:0] sat_value(input int unsigned w,
                                                 input logic is_signed,
                                                 input logic neg);
    logic [MAX_W-1:0] one_v;
    one_v = {{(MAX_W-1){1'b0}}, 1'b1};
    if (!is_signed) begin
      sat_value = (w >= MAX_W) ? {MAX_W{1'b1}} : ((one_v << w) - one_v);
    end else if (neg) begin
      sat_value = one_v << (w - 1);
    end else begin
      sat_value = (one_v << (w - 1)) - one_v;
    end
  endfunction

endpackage

// File: rtl/divider_q_step.sv
// One restoring-division step: compare {rem, bit_in} against the divisor
// magnitude, subtract when it fits, and report the quotient bit.
module div_restore_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem,
  input  logic         bit_in,
  input  logic [W-1:0] divisor_mag,
  output logic [W-1:0] rem_next,
  output logic         q_bit
);

  logic [W:0]   partial_s;
  logic [W-1:0] diff_s;
  logic         ge_s;

  // Since rem < divisor_mag, partial - divisor_mag always fits in W bits.
  always_comb begin
    partial_s = {rem, bit_in};
    ge_s      = (partial_s >= {1'b0, divisor_mag});
    diff_s    = partial_s[W-1:0] - divisor_mag;
    if (ge_s) begin
      rem_next = diff_s;
      q_bit    = 1'b1;
    end else begin
      rem_next = partial_s[W-1:0];
      q_bit    = 1'b0;
    end
  end

endmodule

// File: rtl/divider_q.sv
// Iterative signed/unsigned restoring divider with Q-format quotient,
// remainder, saturation, divide-by-zero flag and valid/ready handshakes.
module divider_q
  import divider_q_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_signed,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  overflow,
  output logic                  div_by_zero
);

  localparam int W  = DATA_WIDTH;
  localparam int F  = FRAC_BITS;
  localparam int N  = W + F;
  localparam int CW = $clog2(N + 1);

  localparam logic [N:0] ONE_N  = {{N{1'b0}}, 1'b1};
  localparam logic [N:0] LIM_U  = (ONE_N << W) - ONE_N;
  localparam logic [N:0] LIM_SP = (ONE_N << (W - 1)) - ONE_N;
  localparam logic [N:0] LIM_SN = ONE_N << (W - 1);

  localparam logic [MAX_W-1:0] SAT_U_FULL = sat_value(W, 1'b0, 1'b0);
  localparam logic [MAX_W-1:0] SAT_P_FULL = sat_value(W, 1'b1, 1'b0);
  localparam logic [MAX_W-1:0] SAT_N_FULL = sat_value(W, 1'b1, 1'b1);
  localparam logic [W-1:0]     SAT_U      = SAT_U_FULL[W-1:0];
  localparam logic [W-1:0]     SAT_P      = SAT_P_FULL[W-1:0];
  localparam logic [W-1:0]     SAT_N      = SAT_N_FULL[W-1:0];

  div_state_t state_r, next_state_s;

  logic          signed_r;
  logic [W-1:0]  dividend_r, divisor_r;
  logic          qneg_r, rneg_r, dz_r;
  logic [W-1:0]  bmag_r;
  logic [N-1:0]  shreg_r;
  logic [W-1:0]  rem_r;
  logic [CW-1:0] cnt_r;

  logic          sa_s, sb_s;
  logic [W-1:0]  amag_s, bmag_s;
  logic [N-1:0]  amag_ext_s;
  logic [W-1:0]  rem_next_s;
  logic          qbit_s;

  logic [N:0]    m_ext_s;
  logic          ovf_s;
  logic [W-1:0]  sat_s, q_fix_s, r_fix_s;
  logic          ov_fix_s;

  div_restore_step #(.W(W)) u_step (
    .rem         (rem_r),
    .bit_in      (shreg_r[N-1]),
    .divisor_mag (bmag_r),
    .rem_next    (rem_next_s),
    .q_bit       (qbit_s)
  );

  // Operand magnitudes and signs, formed from the latched request.
  always_comb begin
    sa_s       = signed_r & dividend_r[W-1];
    sb_s       = signed_r & divisor_r[W-1];
    amag_s     = sa_s ? -dividend_r : dividend_r;
    bmag_s     = sb_s ? -divisor_r : divisor_r;
    amag_ext_s = '0;
    amag_ext_s[W-1:0] = amag_s;
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid && in_ready) next_state_s = PREP;
        else                      next_state_s = IDLE;
      end
      PREP: begin
        if (divisor_r == '0) next_state_s = FIX;
        else                 next_state_s = ITER;
      end
      ITER: begin
        if (cnt_r == '0) next_state_s = FIX;
        else             next_state_s = ITER;
      end
      FIX:     next_state_s = DONE;
      DONE: begin
        if (out_ready) next_state_s = IDLE;
        else           next_state_s = DONE;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Final result: range check on the N-bit magnitude, then sign or saturate.
  always_comb begin
    m_ext_s = {1'b0, shreg_r};
    if (!signed_r) begin
      ovf_s = (m_ext_s > LIM_U);
    end else if (qneg_r) begin
      ovf_s = (m_ext_s > LIM_SN);
    end else begin
      ovf_s = (m_ext_s > LIM_SP);
    end

    if (!signed_r) begin
      sat_s = SAT_U;
    end else if (dz_r ? rneg_r : qneg_r) begin
      sat_s = SAT_N;
    end else begin
      sat_s = SAT_P;
    end

    if (dz_r) begin
      q_fix_s  = sat_s;
      r_fix_s  = dividend_r;
      ov_fix_s = 1'b1;
    end else begin
      q_fix_s  = ovf_s ? sat_s : (qneg_r ? -shreg_r[W-1:0] : shreg_r[W-1:0]);
      r_fix_s  = rneg_r ? -rem_r : rem_r;
      ov_fix_s = ovf_s;
    end
  end

  // Datapath registers and registered handshake/result outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      signed_r    <= 1'b0;
      dividend_r  <= '0;
      divisor_r   <= '0;
      qneg_r      <= 1'b0;
      rneg_r      <= 1'b0;
      dz_r        <= 1'b0;
      bmag_r      <= '0;
      shreg_r     <= '0;
      rem_r       <= '0;
      cnt_r       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
    end else begin
      in_ready  <= (next_state_s == IDLE);
      out_valid <= (next_state_s == DONE);
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready) begin
            signed_r   <= in_signed;
            dividend_r <= dividend;
            divisor_r  <= divisor;
          end
        end
        PREP: begin
          qneg_r  <= sa_s ^ sb_s;
          rneg_r  <= sa_s;
          dz_r    <= (divisor_r == '0);
          bmag_r  <= bmag_s;
          shreg_r <= amag_ext_s << F;
          rem_r   <= '0;
          cnt_r   <= CW'(N - 1);
        end
        ITER: begin
          rem_r   <= rem_next_s;
          shreg_r <= {shreg_r[N-2:0], qbit_s};
          cnt_r   <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
        end
        FIX: begin
          quotient    <= q_fix_s;
          remainder   <= r_fix_s;
          overflow    <= ov_fix_s;
          div_by_zero <= dz_r;
        end
        DONE: begin
          quotient <= quotient;
        end
        default: begin
          cnt_r <= '0;
        end
      endcase
    end
  end

endmodule
